// File: rtl/dct_pkg.sv
// dct_pkg: shared widths, FSM state and row/coefficient types for the DCT row scheduler
package dct_pkg;
  localparam int ROWS   = 8;
  localparam int PIX_W  = 8;
  localparam int COEF_W = 12;
  localparam int NCOEF  = 6;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  typedef logic [8*PIX_W-1:0] row_t;
  typedef logic [NCOEF*COEF_W-1:0] coef_row_t;
endpackage

// File: rtl/dct_pipe_stage.sv
// dct_pipe_stage: single valid/ready register slice with a W-bit payload
module dct_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  assign in_ready = !out_valid || out_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end
endmodule

// File: rtl/dct_row_sched.sv
// dct_row_sched: feeds 8 pixel rows through a 2-stage pipe around the DCT datapath.
// Optional DCT_SCHED_PERF_EN adds a saturating output-stall counter (stall_cnt).
module dct_row_sched #(
  parameter int ROWS   = dct_pkg::ROWS,
  parameter int PIX_W  = dct_pkg::PIX_W,
  parameter int COEF_W = dct_pkg::COEF_W,
  parameter int NCOEF  = dct_pkg::NCOEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    dc_mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [8*PIX_W-1:0]      in_data,
  output logic [8*PIX_W-1:0]      dp_data_in,
  output logic                    dp_control,
  input  logic [NCOEF*COEF_W-1:0] dp_data_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NCOEF*COEF_W-1:0] out_data,
  output logic [2:0]              out_row,
  output logic                    out_last,
`ifdef DCT_SCHED_PERF_EN
  output logic [15:0]             stall_cnt,
`endif
  output logic                    busy,
  output logic                    done
);
  import dct_pkg::*;
  localparam int RW = 8*PIX_W;
  localparam int CW = NCOEF*COEF_W;
  state_t state, state_n;
  logic dc_q, s1_valid, s1_ready, s2_ready, in_hs, out_hs, go;
  logic [3:0] in_cnt, out_cnt;
  logic [2:0] s1_idx;
  assign go       = state == IDLE && start;
  assign in_ready = state == RUN && in_cnt < 4'(ROWS) && s1_ready;
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;
  assign busy     = state == RUN || state == FLUSH;
  assign done     = state == DONE;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (start) state_n = RUN;
      RUN:   if (in_hs && in_cnt == 4'(ROWS-1)) state_n = FLUSH;
      FLUSH: if (out_hs && out_cnt == 4'(ROWS-1)) state_n = DONE;
      DONE:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      dc_q    <= 1'b0;
      in_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      state <= state_n;
      if (go) begin
        dc_q    <= dc_mode;
        in_cnt  <= '0;
        out_cnt <= '0;
      end else begin
        in_cnt  <= in_cnt + 4'(in_hs);
        out_cnt <= out_cnt + 4'(out_hs);
      end
    end
  end
  dct_pipe_stage #(.W(RW+3)) u_s1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_hs), .in_ready(s1_ready), .in_data({in_data, in_cnt[2:0]}),
    .out_valid(s1_valid), .out_ready(s2_ready), .out_data({dp_data_in, s1_idx})
  );
  dct_pipe_stage #(.W(CW+3)) u_s2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s1_valid), .in_ready(s2_ready), .in_data({dp_data_out, s1_idx}),
    .out_valid(out_valid), .out_ready(out_ready), .out_data({out_data, out_row})
  );
  assign dp_control = dc_q && s1_idx == 3'd0 && s1_valid;
  assign out_last   = out_valid && out_row == 3'(ROWS-1);
`ifdef DCT_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt <= '0;
    else if (go) stall_cnt <= '0;
    else if (busy && out_valid && !out_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_dct_row_sched.sv
// tb_dct_row_sched: scoreboard bench for dct_row_sched with a toy datapath model
module tb_dct_row_sched;
  logic clk = 0, rst_n = 0, start = 0, dc_mode = 0, in_valid = 0, out_ready = 1;
  logic [63:0] in_data = '0, dp_data_in;
  logic [71:0] dp_data_out, out_data;
  logic dp_control, in_ready, out_valid, out_last, busy, done;
  logic [2:0] out_row;
`ifdef DCT_SCHED_PERF_EN
  logic [15:0] stall_cnt;
`endif
  int vec = 0, err = 0, cyc = 0, done_cnt = 0, done_cyc = 0;
  int blk_outs = 0, first_cyc = 0, first_out = 0, last_out = 0;
  bit first_v = 0, ctl_chk = 0, hold_v = 0, blk_end = 0;
  logic [71:0] hold_d;
  logic [2:0] hold_r;
  logic [75:0] q[$];

  dct_row_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dc_mode(dc_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .dp_data_in(dp_data_in), .dp_control(dp_control), .dp_data_out(dp_data_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_last(out_last),
`ifdef DCT_SCHED_PERF_EN
    .stall_cnt(stall_cnt),
`endif
    .busy(busy), .done(done)
  );

  // toy datapath: tag byte reveals dp_control, remaining bits echo the row
  assign dp_data_out = {dp_control ? 8'hA5 : 8'h00, dp_data_in};

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [75:0] e;
    if (!rst_n) hold_v = 0;
    else begin
      if (hold_v && out_valid) begin
        chk("stall_data", out_data, hold_d);
        chk("stall_row", 72'(out_row), 72'(hold_r));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          vec++; err++;
          $display("FAIL unexpected_out: got row %0d expected no output", out_row);
        end else begin
          e = q.pop_front();
          chk("out_data", out_data, e[75:4]);
          chk("out_row", 72'(out_row), 72'(e[3:1]));
          chk("out_last", 72'(out_last), 72'(e[0]));
          if (blk_outs == 0) first_out = cyc;
          last_out = cyc;
          blk_outs++;
        end
      end
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
      hold_r = out_row;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("busy_at_done", 72'(busy), 72'(0));
      end
      if (ctl_chk && first_v && cyc == first_cyc) chk("dp_control_row0", 72'(dp_control), 72'(1));
      if (ctl_chk && first_v && cyc == first_cyc + 1) chk("dp_control_row1", 72'(dp_control), 72'(0));
    end
  end

  function automatic logic [63:0] mk(input int pat, input int i);
    return pat == 0 ? 64'h0101010101010101 : {8'(i), 56'h0};
  endfunction

  task automatic do_start(input bit dc);
    start = 1; dc_mode = dc;
    @(posedge clk); #1;
    start = 0; dc_mode = 0;
  endtask

  task automatic send_row(input logic [63:0] row, input bit ctl, input int idx);
    bit hs = 0;
    in_valid = 1; in_data = row;
    for (int t = 0; t < 200 && !hs; t++) begin
      @(negedge clk); hs = in_ready;
      @(posedge clk); #1;
    end
    if (!hs) begin
      vec++; err++;
      $display("FAIL in_timeout: row %0d never accepted, expected handshake", idx);
    end else begin
      q.push_back({ctl ? 8'hA5 : 8'h00, row, 3'(idx), idx == 7});
      if (idx == 0) begin first_cyc = cyc; first_v = 1; end
    end
    in_valid = 0;
  endtask

  task automatic run_block(input bit dc, input int pat, input bit gap, input bit restart, input bit pclr);
    int d0 = done_cnt;
    blk_end = 0; blk_outs = 0; first_v = 0;
    do_start(dc);
    chk("busy_after_start", 72'(busy), 72'(1));
`ifdef DCT_SCHED_PERF_EN
    if (pclr) chk("stall_cnt_clear", 72'(stall_cnt), 72'(0));
`endif
    for (int i = 0; i < 8; i++) begin
      if (restart && i == 3) begin
        start = 1; dc_mode = ~dc;
        @(posedge clk); #1;
        start = 0; dc_mode = 0;
      end
      send_row(mk(pat, i), dc && i == 0, i);
      if (gap && i == 5) begin repeat (3) @(posedge clk); #1; end
    end
    for (int t = 0; t < 300 && done_cnt == d0; t++) @(posedge clk);
    if (done_cnt == d0) begin
      vec++; err++;
      $display("FAIL done_timeout: got no done expected one");
    end
    repeat (3) @(posedge clk); #1;
    blk_end = 1;
    chk("done_once", 72'(done_cnt), 72'(d0 + 1));
    chk("outs_per_block", 72'(blk_outs), 72'(8));
    chk("queue_empty", 72'(q.size()), 72'(0));
    chk("idle_in_ready", 72'(in_ready), 72'(0));
  endtask

  initial begin
    repeat (3) @(posedge clk); #1;
    chk("rst_in_ready", 72'(in_ready), 72'(0));
    chk("rst_out_valid", 72'(out_valid), 72'(0));
    chk("rst_busy", 72'(busy), 72'(0));
    chk("rst_done", 72'(done), 72'(0));
    chk("rst_dp_data_in", 72'(dp_data_in), 72'(0));
    chk("rst_dp_control", 72'(dp_control), 72'(0));
    chk("rst_out_data", out_data, 72'(0));
    chk("rst_out_row", 72'({out_row, out_last}), 72'(0));
`ifdef DCT_SCHED_PERF_EN
    chk("rst_stall_cnt", 72'(stall_cnt), 72'(0));
`endif
    rst_n = 1;
    @(posedge clk); #1;
    // back-to-back block with DC mode, latency and throughput
    ctl_chk = 1;
    run_block(1, 0, 0, 0, 0);
    ctl_chk = 0;
    chk("first_latency", 72'(first_out), 72'(first_cyc + 1));
    chk("throughput", 72'(last_out), 72'(first_out + 7));
    chk("done_timing", 72'(done_cyc), 72'(last_out + 1));
    // out_ready toggling every cycle
    fork
      run_block(0, 1, 0, 0, 0);
      begin
        while (!blk_end) begin @(posedge clk); #1; out_ready = ~out_ready; end
        out_ready = 1;
      end
    join
    // start pulse while busy is ignored
    run_block(1, 1, 0, 1, 0);
    // asynchronous reset mid-block
    do_start(0);
    for (int i = 0; i < 4; i++) send_row(mk(1, i), 0, i);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_out_valid", 72'(out_valid), 72'(0));
    chk("mid_rst_busy", 72'(busy), 72'(0));
    chk("mid_rst_dp_data_in", 72'(dp_data_in), 72'(0));
    chk("mid_rst_out_data", out_data, 72'(0));
    chk("mid_rst_in_ready", 72'(in_ready), 72'(0));
    q.delete();
    repeat (2) @(posedge clk); #1;
    rst_n = 1; in_valid = 1;
    repeat (3) begin @(negedge clk); chk("post_rst_in_ready", 72'(in_ready), 72'(0)); end
    @(posedge clk); #1; in_valid = 0;
    run_block(0, 1, 0, 0, 0);
    // input gap between rows 5 and 6
    run_block(1, 1, 1, 0, 0);
    // out_ready held low 10 cycles mid-block
    fork
      run_block(0, 1, 0, 0, 0);
      begin
        for (int t = 0; t < 300 && blk_outs < 3; t++) @(posedge clk);
        #1 out_ready = 0;
        repeat (10) @(posedge clk);
        #1 out_ready = 1;
      end
    join
`ifdef DCT_SCHED_PERF_EN
    chk("stall_cnt_after_done", 72'(stall_cnt), 72'(10));
`endif
    run_block(0, 0, 0, 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
